sram22_host_port: RTL and testbench

// - Initiator-side adapter that drives one sram22 single-port macro (clk/we/wmask/addr/din/dout).
// - Accepts valid/ready read/write requests and issues at most one SRAM access per cycle.
// - Captures read data one cycle after issue and returns it in order on a valid/ready response

---
 rtl/sram22_host_port.sv | 113 +++++++++++
 tb/tb_sram22_host_port.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_host_port.sv
// Host-side adapter for one sram22 single-port macro: valid/ready requests in, in-order read data
// out through a credit-guarded response FIFO. Optional counters: SRAM22_HOST_PORT_STATS_EN.
module sram22_host_port #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WMASK_WIDTH = 8,
  parameter int unsigned RSP_DEPTH   = 3
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
`ifdef SRAM22_HOST_PORT_STATS_EN
  ,
  output logic [31:0]            stat_reads,
  output logic [31:0]            stat_writes
`endif
);

  localparam int unsigned PtrW = $clog2(RSP_DEPTH);
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  logic                  ready_en_q;
  logic                  rd_pend_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       cnt_q;
  logic [CntW:0]         used;
  logic                  fire, rd_fire, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Reserve a FIFO slot for every read in flight so a capture can never overflow.
  assign used      = {1'b0, cnt_q} + (CntW + 1)'(rd_pend_q);
  assign req_ready = ready_en_q & (used < (CntW + 1)'(RSP_DEPTH));
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & ~req_we;
  assign push      = rd_pend_q;
  assign pop       = rsp_ready & (cnt_q != '0);

  assign sram_we    = fire & req_we;
  assign sram_wmask = sram_we ? req_wmask : '0;
  assign sram_addr  = fire ? req_addr : addr_q;
  assign sram_din   = fire ? req_wdata : din_q;

  assign rsp_valid = (cnt_q != '0);
  assign rsp_rdata = fifo_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ready_en_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      // Holds req_ready low until the first clock after reset release.
      ready_en_q <= 1'b1;
      rd_pend_q  <= rd_fire;
      if (fire) begin
        addr_q <= req_addr;
        din_q  <= req_wdata;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= sram_dout;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef SRAM22_HOST_PORT_STATS_EN
  logic [31:0] stat_reads_q, stat_writes_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      if (rd_fire && stat_reads_q != 32'hFFFF_FFFF) stat_reads_q <= stat_reads_q + 32'd1;
      if (sram_we && stat_writes_q != 32'hFFFF_FFFF) stat_writes_q <= stat_writes_q + 32'd1;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_sram22_host_port.sv
// Self-checking bench for sram22_host_port with a behavioural sram22 macro model.
module tb_sram22_host_port;

  localparam logic [63:0] Poison = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rstb;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_wmask;
  logic [8:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic        sram_we;
  logic [7:0]  sram_wmask;
  logic [8:0]  sram_addr;
  logic [63:0] sram_din, sram_dout;
`ifdef SRAM22_HOST_PORT_STATS_EN
  logic [31:0] stat_reads, stat_writes;
`endif

  int checks   = 0;
  int failures = 0;
  logic mem_init;
  logic [63:0] mem [512];

  always #5 clk = ~clk;

  sram22_host_port dut (
    .clk        (clk),
    .rstb       (rstb),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
`ifdef SRAM22_HOST_PORT_STATS_EN
    ,
    .stat_reads (stat_reads),
    .stat_writes(stat_writes)
`endif
  );

  function automatic logic [63:0] pat(input int a);
    return {32'hC0DE_0000 | 32'(a), 32'h5A5A_0000 | 32'(a)};
  endfunction

  // Macro model: one-cycle read latency, dout poisoned after a write.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= pat(i);
    end else if (sram_we) begin
      for (int b = 0; b < 8; b++)
        if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      sram_dout <= Poison;
    end else begin
      sram_dout <= mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_op(input logic we, input logic [8:0] addr, input logic [7:0] mask,
                       input logic [63:0] data, input logic [63:0] exp, input string name);
    int n = 0;
    rsp_ready = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " credit"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wmask = mask;
    req_wdata = data;
    #1;
    check({name, " sram_we"}, 64'(sram_we), 64'(we));
    check({name, " sram_wmask"}, 64'(sram_wmask), we ? 64'(mask) : 64'd0);
    check({name, " sram_addr"}, 64'(sram_addr), 64'(addr));
    if (we) check({name, " sram_din"}, sram_din, data);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 9'h1AA;
    #1;
    check({name, " idle we"}, 64'(sram_we), 64'd0);
    check({name, " idle wmask"}, 64'(sram_wmask), 64'd0);
    check({name, " idle addr held"}, 64'(sram_addr), 64'(addr));
    check({name, " rsp early"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check({name, " rsp_valid"}, 64'(rsp_valid), we ? 64'd0 : 64'd1);
    if (!we) check({name, " rdata"}, rsp_rdata, exp);
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int acc;
    vecs[0] = '{1'b1, 9'd5,   8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[1] = '{1'b0, 9'd5,   8'h00, 64'h0, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{1'b1, 9'd7,   8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[3] = '{1'b1, 9'd7,   8'h0F, 64'h0, 64'h0};
    vecs[4] = '{1'b0, 9'd7,   8'h00, 64'h0, 64'hFFFF_FFFF_0000_0000};
    vecs[5] = '{1'b1, 9'd7,   8'h00, 64'h1234_5678_1234_5678, 64'h0};
    vecs[6] = '{1'b0, 9'd7,   8'h00, 64'h0, 64'hFFFF_FFFF_0000_0000};
    vecs[7] = '{1'b0, 9'd10,  8'h00, 64'h0, 64'hC0DE_000A_5A5A_000A};
    vecs[8] = '{1'b1, 9'd511, 8'h81, 64'hAA00_0000_0000_00BB, 64'h0};
    vecs[9] = '{1'b0, 9'd511, 8'h00, 64'h0, 64'hAADE_01FF_5A5A_01BB};

    rstb = 1'b0;
    mem_init = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_wmask = '0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    mem_init = 1'b0;
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset req_ready", 64'(req_ready), 64'd0);
    check("reset rsp_rdata", rsp_rdata, 64'd0);
    check("reset sram_we", 64'(sram_we), 64'd0);
    rstb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post-reset req_ready", 64'(req_ready), 64'd1);

    // Stream of 16 reads with the consumer always ready.
    rsp_ready = 1'b1;
    for (int n = 0; n < 18; n++) begin
      if (n >= 2) begin
        check("stream rsp_valid", 64'(rsp_valid), 64'd1);
        check("stream rdata", rsp_rdata, pat(n - 2));
      end
      if (n < 16) begin
        check("stream req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 9'(n);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("stream drained", 64'(rsp_valid), 64'd0);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].we, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].exp,
            $sformatf("vec%0d", i));

    // Write then read of the same address in consecutive cycles.
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 9'd12;
    req_wmask = 8'hF0;
    req_wdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    req_we = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("wr->rd valid", 64'(rsp_valid), 64'd1);
    check("wr->rd data", rsp_rdata, 64'h1111_2222_5A5A_000C);
    @(negedge clk);

    // Backpressure: only RSP_DEPTH reads accepted while the consumer stalls.
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 9'(20 + acc);
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("bp accepted", 64'(acc), 64'd3);
    check("bp req_ready", 64'(req_ready), 64'd0);
    check("bp head", rsp_rdata, pat(20));
    @(negedge clk);
    check("bp head stable", rsp_rdata, pat(20));
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp drain valid", 64'(rsp_valid), 64'd1);
      check("bp drain data", rsp_rdata, pat(20 + k));
      if (k == 1) check("bp credit back", 64'(req_ready), 64'd1);
      @(negedge clk);
    end
    check("bp empty", 64'(rsp_valid), 64'd0);
    do_op(1'b0, 9'd23, 8'h00, 64'h0, pat(23), "bp next read");

    // Reset with two FIFO entries and a read in flight.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst fill ready", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 9'(40 + k);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("rst fill valid", 64'(rsp_valid), 64'd1);
    rstb = 1'b0;
    #1;
    check("rst async rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst async req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst no stale", 64'(rsp_valid), 64'd0);
    end
    do_op(1'b0, 9'd50, 8'h00, 64'h0, pat(50), "post-rst read");

`ifdef SRAM22_HOST_PORT_STATS_EN
    do_reset();
    check("stats reset reads", 64'(stat_reads), 64'd0);
    check("stats reset writes", 64'(stat_writes), 64'd0);
    for (int k = 0; k < 4; k++) do_op(1'b1, 9'(60 + k), 8'hFF, 64'(k), 64'h0, "stats wr");
    for (int k = 0; k < 6; k++) do_op(1'b0, 9'(100 + k), 8'h00, 64'h0, pat(100 + k), "stats rd");
    check("stats writes", 64'(stat_writes), 64'd4);
    check("stats reads", 64'(stat_reads), 64'd6);
    force dut.stat_reads_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_reads_q;
    for (int k = 0; k < 3; k++) do_op(1'b0, 9'(110 + k), 8'h00, 64'h0, pat(110 + k), "sat rd");
    check("stats saturate", 64'(stat_reads), 64'hFFFF_FFFF);
    check("stats writes kept", 64'(stat_writes), 64'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
